// File: rtl/c17_bist_pkg.sv
// rtl/c17_bist_pkg.sv - shared types, widths, tap positions and MISR step for the c17 BIST harness
package c17_bist_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int LFSR_W = 5;
  localparam int MISR_W = 16;

  localparam int LFSR_TAP_A = 4;
  localparam int LFSR_TAP_B = 2;

  localparam int MISR_TAP_A = 15;
  localparam int MISR_TAP_B = 14;
  localparam int MISR_TAP_C = 12;
  localparam int MISR_TAP_D = 3;

  function automatic logic [MISR_W-1:0] misr_next(input logic [MISR_W-1:0] sig, input logic resp);
    return {sig[MISR_W-2:0],
            sig[MISR_TAP_A] ^ sig[MISR_TAP_B] ^ sig[MISR_TAP_C] ^ sig[MISR_TAP_D] ^ resp};
  endfunction

endpackage

// File: rtl/bist_lfsr.sv
// rtl/bist_lfsr.sv - 5-bit Fibonacci LFSR (x^5+x^3+1) with load and enable
module bist_lfsr
  import c17_bist_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 5'h01
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              enable,
  output logic [LFSR_W-1:0] value
);

  // Load wins over enable so a run always starts from a known non-zero state.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      value <= SEED;
    end else if (enable) begin
      value <= {value[LFSR_W-2:0], value[LFSR_TAP_A] ^ value[LFSR_TAP_B]};
    end
  end

endmodule

// File: rtl/c17_bist.sv
// rtl/c17_bist.sv - LFSR stimulus generator, MISR response compactor and run FSM around c17
module c17_bist
  import c17_bist_pkg::*;
#(
  parameter int                NUM_PATTERNS = 31,
  parameter logic [LFSR_W-1:0] SEED         = 5'h01,
  parameter logic [MISR_W-1:0] GOLDEN       = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [LFSR_W-1:0] pattern,
  input  logic              resp,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [4:0]        count,
  output logic [MISR_W-1:0] signature
);

  state_t            state;
  logic              last_capture;
  logic              lfsr_load;
  logic              lfsr_en;
  logic [MISR_W-1:0] sig_next;

  assign sig_next     = misr_next(signature, resp);
  assign last_capture = (count == 5'(NUM_PATTERNS - 1));

  // The generator is reseeded both on run entry and on the final capture,
  // so DONE presents SEED while the result is held.
  assign lfsr_load = ((state != RUN) && start) || ((state == RUN) && last_capture);
  assign lfsr_en   = (state == RUN);

  bist_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .load   (lfsr_load),
    .enable (lfsr_en),
    .value  (pattern)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      count     <= 5'd0;
      signature <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= RUN;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            count     <= 5'd0;
            signature <= '0;
          end
        end
        RUN: begin
          signature <= sig_next;
          count     <= count + 5'd1;
          if (last_capture) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (sig_next == GOLDEN);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          pass  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_c17_bist.sv
// tb/tb_c17_bist.sv - self-checking bench for c17_bist at 31, 6 and 4 patterns
module tb_c17_bist;

  typedef struct {
    logic [4:0]  pat;
    logic        resp;
    logic [15:0] sig;
  } vec_t;

  logic clk;
  logic rst;
  logic start;

  logic [4:0]  pattern_a, pattern_b, pattern_c;
  logic        resp_a, resp_b, resp_c;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;
  logic        pass_a, pass_b, pass_c;
  logic [4:0]  count_a, count_b, count_c;
  logic [15:0] sig_a, sig_b, sig_c;

  int checks;
  int failures;

  logic [15:0] exp_a[$];
  logic [15:0] exp_b[$];
  logic [15:0] exp_c[$];

  vec_t tab_b[6];
  vec_t tab_c[4];

  function automatic logic c17_k(input logic [4:0] p);
    logic n10, n11, n16;
    n10 = ~(p[0] & p[2]);
    n11 = ~(p[2] & p[3]);
    n16 = ~(p[1] & n11);
    return ~(n10 & n16);
  endfunction

  function automatic logic [4:0] lfsr_step(input logic [4:0] s);
    return {s[3:0], s[4] ^ s[2]};
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic r);
    return {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3] ^ r};
  endfunction

  function automatic logic [15:0] full_sig_a();
    logic [4:0]  l;
    logic [15:0] s;
    l = 5'h01;
    s = 16'h0000;
    for (int i = 0; i < 31; i++) begin
      s = misr_step(s, c17_k(l));
      l = lfsr_step(l);
    end
    return s;
  endfunction

  assign resp_a = c17_k(pattern_a);

  c17_bist u_dut_a (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern_a), .resp(resp_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .count(count_a), .signature(sig_a)
  );

  c17_bist #(.NUM_PATTERNS(6)) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern_b), .resp(resp_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .count(count_b), .signature(sig_b)
  );

  c17_bist #(.NUM_PATTERNS(4)) u_dut_c (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern_c), .resp(resp_c),
    .busy(busy_c), .done(done_c), .pass(pass_c), .count(count_c), .signature(sig_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    logic [4:0]  m_lfsr;
    logic [15:0] m_sig;
    logic        seen[32];
    int          distinct;

    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    start    = 1'b0;
    resp_b   = 1'b0;
    resp_c   = 1'b0;
    for (int i = 0; i < 32; i++) seen[i] = 1'b0;

    tab_b[0] = '{5'h01, 1'b0, 16'h0000};
    tab_b[1] = '{5'h02, 1'b0, 16'h0000};
    tab_b[2] = '{5'h04, 1'b0, 16'h0000};
    tab_b[3] = '{5'h09, 1'b0, 16'h0000};
    tab_b[4] = '{5'h12, 1'b0, 16'h0000};
    tab_b[5] = '{5'h05, 1'b0, 16'h0000};
    tab_c[0] = '{5'h01, 1'b1, 16'h0001};
    tab_c[1] = '{5'h02, 1'b0, 16'h0002};
    tab_c[2] = '{5'h04, 1'b0, 16'h0004};
    tab_c[3] = '{5'h09, 1'b0, 16'h0008};

    // Reset, then idle.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_pattern", 32'(pattern_a), 32'h01);
    chk("rst_busy", 32'(busy_a), 32'h0);
    chk("rst_done", 32'(done_a), 32'h0);
    chk("rst_pass", 32'(pass_a), 32'h0);
    chk("rst_count", 32'(count_a), 32'h0);
    chk("rst_sig", 32'(sig_a), 32'h0);

    // Concurrent run on all three instances.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("run_busy_a", 32'(busy_a), 32'h1);
    chk("run_seed_a", 32'(pattern_a), 32'h01);
    m_lfsr = 5'h01;
    m_sig  = 16'h0000;
    for (int k = 1; k <= 31; k++) begin
      chk("a_pattern", 32'(pattern_a), 32'(m_lfsr));
      seen[pattern_a] = 1'b1;
      m_sig = misr_step(m_sig, c17_k(m_lfsr));
      exp_a.push_back(m_sig);
      m_lfsr = lfsr_step(m_lfsr);
      if (k <= 6) begin
        chk("b_pattern", 32'(pattern_b), 32'(tab_b[k-1].pat));
        resp_b = tab_b[k-1].resp;
        exp_b.push_back(tab_b[k-1].sig);
      end
      if (k <= 4) begin
        chk("c_pattern", 32'(pattern_c), 32'(tab_c[k-1].pat));
        resp_c = tab_c[k-1].resp;
        exp_c.push_back(tab_c[k-1].sig);
      end else begin
        resp_c = 1'b0;
      end
      @(negedge clk);
      chk("a_sig", 32'(sig_a), 32'(exp_a.pop_front()));
      if (k <= 6) chk("b_sig", 32'(sig_b), 32'(exp_b.pop_front()));
      if (k <= 4) chk("c_sig", 32'(sig_c), 32'(exp_c.pop_front()));
      if (k < 31) chk("a_busy_mid", 32'(busy_a), 32'h1);
      if (k == 4) begin
        chk("c_done", 32'(done_c), 32'h1);
        chk("c_busy", 32'(busy_c), 32'h0);
        chk("c_count", 32'(count_c), 32'd4);
        chk("c_pass", 32'(pass_c), 32'h0);
      end
      if (k == 5) chk("b_pass_pre", 32'(pass_b), 32'h0);
      if (k == 6) begin
        chk("b_done", 32'(done_b), 32'h1);
        chk("b_busy", 32'(busy_b), 32'h0);
        chk("b_count", 32'(count_b), 32'd6);
        chk("b_pass", 32'(pass_b), 32'h1);
      end
      if (k == 10) begin
        chk("b_hold_done", 32'(done_b), 32'h1);
        chk("b_hold_count", 32'(count_b), 32'd6);
        chk("b_hold_pattern", 32'(pattern_b), 32'h01);
        chk("c_hold_sig", 32'(sig_c), 32'h0008);
        chk("c_hold_count", 32'(count_c), 32'd4);
      end
    end
    chk("a_done", 32'(done_a), 32'h1);
    chk("a_busy_end", 32'(busy_a), 32'h0);
    chk("a_count", 32'(count_a), 32'd31);
    chk("a_final_sig", 32'(sig_a), 32'(full_sig_a()));
    chk("a_pass", 32'(pass_a), 32'(full_sig_a() == 16'h0000));
    chk("a_done_pattern", 32'(pattern_a), 32'h01);
    distinct = 0;
    for (int i = 0; i < 32; i++) if (seen[i]) distinct++;
    chk("a_distinct", 32'(distinct), 32'd31);
    chk("a_zero_unseen", 32'(seen[0]), 32'h0);

    // Reset at capture 3 of a run.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", 32'(busy_a), 32'h0);
    chk("mid_rst_done", 32'(done_a), 32'h0);
    chk("mid_rst_pass", 32'(pass_a), 32'h0);
    chk("mid_rst_count", 32'(count_a), 32'h0);
    chk("mid_rst_sig", 32'(sig_a), 32'h0);
    chk("mid_rst_pattern", 32'(pattern_a), 32'h01);

    // rst and start together: rst wins.
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    chk("rst_start_busy", 32'(busy_a), 32'h0);
    @(negedge clk);
    chk("rst_start_idle", 32'(busy_a), 32'h0);

    // Full rerun reproduces the reference signature.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (31) @(negedge clk);
    chk("rerun_done", 32'(done_a), 32'h1);
    chk("rerun_sig", 32'(sig_a), 32'(full_sig_a()));

    // start held through a run of B, then still high in DONE.
    resp_b = 1'b1;
    start  = 1'b1;
    @(negedge clk);
    chk("hold_busy_b", 32'(busy_b), 32'h1);
    m_sig = 16'h0000;
    for (int k = 1; k <= 6; k++) begin
      m_sig = misr_step(m_sig, 1'b1);
      exp_b.push_back(m_sig);
      @(negedge clk);
      chk("hold_sig_b", 32'(sig_b), 32'(exp_b.pop_front()));
      chk("hold_count_b", 32'(count_b), 32'(k));
    end
    chk("hold_done_b", 32'(done_b), 32'h1);
    @(negedge clk);
    start = 1'b0;
    chk("restart_busy_b", 32'(busy_b), 32'h1);
    chk("restart_sig_b", 32'(sig_b), 32'h0);
    chk("restart_count_b", 32'(count_b), 32'h0);
    chk("restart_pattern_b", 32'(pattern_b), 32'h01);
    chk("restart_pass_b", 32'(pass_b), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/c17_bist.md
# c17_bist

Built-in self-test driver that sits directly upstream and downstream of the c17 netlist. It generates pseudo-random 5-bit input vectors for I1..I5 with a maximal-length LFSR and compacts the c17 output K into a 16-bit serial signature register (MISR). On completion it compares the signature against a golden value. It gives the critical-path experiments a self-contained, repeatable stimulus/response harness around the combinational benchmark.

## Interface

Parameters:
- NUM_PATTERNS, default 31: vectors applied per run; legal range 1..31.
- SEED, default 5'h01: LFSR load value; must be non-zero.
- GOLDEN, default 16'h0000: expected final signature.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  run request; sampled only in IDLE or DONE.
- pattern  output  5  vector to the c17 block: pattern[0]=I1 … pattern[4]=I5.
- resp  input  1  c17 output K, combinationally derived from pattern.
- busy  output  1  high while in RUN.
- done  output  1  high in DONE; level, not pulse.
- pass  output  1  valid only when done=1: (signature == GOLDEN).
- count  output  5  number of responses captured in the current/last run.
- signature  output  16  MISR contents.

## Operation

- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on start=1.
  - RUN→DONE after the NUM_PATTERNS-th capture.
  - DONE→RUN on start=1.
  - No other transitions.
- Run entry (from IDLE or DONE): lfsr←SEED, signature←0, count←0.
- Each RUN cycle:
  - resp is sampled for the currently driven pattern.
  - signature ← {sig[14:0], sig[15]^sig[14]^sig[12]^sig[3]^resp}.
  - lfsr ← {lfsr[3:0], lfsr[4]^lfsr[2]}, polynomial x^5+x^3+1, period 31.
  - count increments.
- pattern = lfsr register output directly; no combinational path from inputs to pattern.
- start while in RUN is ignored and does not restart.
- In DONE, signature, count and pass hold until the next start or rst. pattern reloads SEED.
- The LFSR never reaches all-zero; the all-zero vector is never applied.
- pass is 0 outside DONE.

## Timing

- Reset values: state=IDLE, pattern=SEED, busy=0, done=0, pass=0, count=0, signature=16'h0000.
- Edge E samples start=1: from E, busy=1 and pattern=SEED; first capture at E+1.
- Capture k occurs at edge E+k with pattern k-1 driven during the preceding cycle. resp must settle within one cycle.
- Final capture at E+NUM_PATTERNS also enters DONE: busy=0, done=1, count=NUM_PATTERNS, pass valid in the same cycle.
- Latency start→done = NUM_PATTERNS edges. Back-to-back runs need one DONE cycle between them.
- rst mid-RUN: next cycle all reset values apply; no partial signature is retained.
- rst and start high in the same cycle: rst wins, state=IDLE.
- NUM_PATTERNS=31: pattern sequence covers all 31 non-zero vectors exactly once.

## Structure

- Package c17_bist_pkg holds:
  - the state enum (IDLE, RUN, DONE)
  - LFSR_W=5 and MISR_W=16
  - the LFSR tap constants (4,2) and MISR tap constants (15,14,12,3)
- One sub-module, bist_lfsr: 5-bit Fibonacci LFSR with load/enable, reused for pattern generation.
- MISR and FSM live in the top module.
- The top instantiates nothing from the c17 netlist; the harness connects pattern/resp to c17 externally.

## Test plan

- Reset then idle 5 cycles → pattern=5'h01, busy=0, done=0, count=0, signature=16'h0000.
- start pulse, resp tied 0, NUM_PATTERNS=6 → pattern sequence 01,02,04,09,12,05; done after 6 edges; signature=0; pass=1 with GOLDEN=0.
- NUM_PATTERNS=4, resp=1 only on first capture → signature 0001,0002,0004,0008; final 16'h0008; pass=0 with GOLDEN=0.
- NUM_PATTERNS=31 with real c17 attached → 31 distinct non-zero patterns observed, count=31, signature equals reference-model value.
- rst asserted at capture 3 of a run → next cycle all reset values. A subsequent start reproduces the full-run signature bit-exactly.
- start held high throughout RUN, then re-pulsed in DONE → no restart mid-run; the second run begins from SEED with signature cleared.
